// File: rtl/pc_sequencer.sv
// Program counter sequencer: BOOT/RUN/HALT control, branch/jump/call/ret, return stack.
// Optional PC_STACK_GUARD_EN halts on stack overflow/underflow instead of wrapping.
module pc_sequencer #(
  parameter int         STACK_DEPTH  = 4,
  parameter logic [7:0] RESET_VECTOR = 8'd0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] iOp,
  input  logic [7:0] iTarget,
  input  logic       iCondition,
  input  logic       iStall,
  output logic [7:0] oIP,
  output logic [3:0] oDepth,
  output logic       oOverflow,
  output logic       oUnderflow,
  output logic       oHalted
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [3:0] FULL = 4'(STACK_DEPTH);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t state, state_n;

  logic [7:0] ip, ip_n, ip_inc;
  logic [3:0] depth, depth_n;
  logic       ovf, ovf_n;
  logic       unf, unf_n;
  logic       push, shift;
  logic       full, empty;

  logic [AW-1:0] wr_idx, top_idx;
  logic [7:0]    stk [STACK_DEPTH];

  assign ip_inc  = ip + 8'd1;
  assign full    = (depth == FULL);
  assign empty   = (depth == 4'd0);
  assign wr_idx  = AW'(depth);
  assign top_idx = AW'(depth - 4'd1);

  always_comb begin
    state_n = state;
    ip_n    = ip;
    depth_n = depth;
    ovf_n   = ovf;
    unf_n   = unf;
    push    = 1'b0;
    shift   = 1'b0;
    unique case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (!iStall) begin
          case (iOp)
            3'd1: ip_n = iTarget;
            3'd2: ip_n = iCondition ? iTarget : ip_inc;
            3'd3: begin
              if (!full) begin
                push    = 1'b1;
                depth_n = depth + 4'd1;
                ip_n    = iTarget;
              end else begin
`ifdef PC_STACK_GUARD_EN
                ovf_n   = 1'b1;
                state_n = HALT;
`else
                // full stack: oldest return address is dropped
                push    = 1'b1;
                shift   = 1'b1;
                ip_n    = iTarget;
                ovf_n   = 1'b1;
`endif
              end
            end
            3'd4: begin
              if (!empty) begin
                ip_n    = stk[top_idx];
                depth_n = depth - 4'd1;
              end else begin
`ifdef PC_STACK_GUARD_EN
                unf_n   = 1'b1;
                state_n = HALT;
`else
                ip_n    = RESET_VECTOR;
                unf_n   = 1'b1;
`endif
              end
            end
            default: ip_n = ip_inc;
          endcase
        end
      end
      HALT: state_n = HALT;
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= BOOT;
      ip    <= RESET_VECTOR;
      depth <= 4'd0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      state <= state_n;
      ip    <= ip_n;
      depth <= depth_n;
      ovf   <= ovf_n;
      unf   <= unf_n;
    end
  end

  // stack contents need no reset; entries above depth are dead
  always_ff @(posedge Clock) begin
    if (push) begin
      if (shift) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++)
          stk[i] <= stk[i+1];
        stk[STACK_DEPTH-1] <= ip_inc;
      end else begin
        stk[wr_idx] <= ip_inc;
      end
    end
  end

  assign oIP        = ip;
  assign oDepth     = depth;
  assign oOverflow  = ovf;
  assign oUnderflow = unf;
  assign oHalted    = (state == HALT);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, number of return-address entries (2..8).
REQ-002 SHALL have parameter RESET_VECTOR, default 8'd0, first instruction address after reset.
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port iOp  input  3  decoded flow class: 0 NEXT, 1 JMP, 2 BRANCH, 3 CALL, 4 RET, 5-7 treated as NEXT.
REQ-006 SHALL have port iTarget  input  8  jump/branch/call destination address.
REQ-007 SHALL have port iCondition  input  1  branch-taken result from the ALU compare (BEQ/BLE); used only for BRANCH.
REQ-008 SHALL have port iStall  input  1  datapath busy (VGA/LCD/RKB wait); holds the current instruction.
REQ-009 SHALL have port oIP  output  8  registered instruction address driven to the ROM.
REQ-010 SHALL have port oDepth  output  4  current number of valid return-stack entries.
REQ-011 SHALL have port oOverflow  output  1  sticky flag: CALL issued with stack full.
REQ-012 SHALL have port oUnderflow  output  1  sticky flag: RET issued with stack empty.
REQ-013 SHALL have port oHalted  output  1  high while FSM is in HALT.

Function
REQ-014 SHALL implement FSM states BOOT, RUN, HALT; BOOT -> RUN unconditionally on the first edge after reset release.
REQ-015 SHALL, in BOOT, hold oIP = RESET_VECTOR and ignore iOp/iStall.
REQ-016 SHALL, in RUN with iStall=1, hold oIP, stack and flags unchanged regardless of iOp.
REQ-017 SHALL, in RUN with iStall=0, update oIP one edge after the instruction is presented (one instruction per cycle, latency 1).
REQ-018 SHALL on NEXT load oIP+1, modulo 256 (8'hFF -> 8'h00).
REQ-019 SHALL on JMP load iTarget.
REQ-020 SHALL on BRANCH load iTarget if iCondition=1, else oIP+1.
REQ-021 SHALL on CALL with oDepth<STACK_DEPTH push oIP+1 (mod 256), increment oDepth, load iTarget.
REQ-022 SHALL on RET with oDepth>0 load the top entry, pop it, decrement oDepth.
REQ-023 SHALL support nested CALL up to STACK_DEPTH levels with LIFO return order.
REQ-024 SHALL, in HALT, hold oIP, oDepth and flags until reset; oHalted=1.
REQ-025 SHALL treat a CALL/RET on the same edge as reset deassertion as ignored (BOOT rule applies).

Reset
REQ-026 SHALL, on Reset=0 at any time (including mid-CALL or in HALT), immediately force state BOOT, oIP=RESET_VECTOR, oDepth=0, oOverflow=0, oUnderflow=0, oHalted=0.
REQ-027 SHALL not require stack entry contents to be cleared; entries above oDepth are don't-care.

Configuration
REQ-028 SHALL use macro PC_STACK_GUARD_EN to select stack-fault handling.
REQ-029 SHALL, with PC_STACK_GUARD_EN defined, on CALL with stack full or RET with stack empty set the matching flag, leave stack and oIP unchanged, and enter HALT next edge.
REQ-030 SHALL, without PC_STACK_GUARD_EN, on CALL with stack full discard the oldest entry, push oIP+1, keep oDepth=STACK_DEPTH, load iTarget, set oOverflow; on RET with stack empty load RESET_VECTOR, keep oDepth=0, set oUnderflow; FSM stays in RUN and oHalted never asserts.

Verification
REQ-031 SHALL cover: reset release, NEXT x3, iOp=1 iTarget=10 -> oIP 0,0(BOOT),1,2,3,10.
REQ-032 SHALL cover: oIP=15, iOp=2, iTarget=20, iCondition=0 then at 16 iCondition=1 -> oIP 16 then 20.
REQ-033 SHALL cover: at oIP=2 CALL 100, at 117 RET -> oIP 100 with oDepth=1, then 3 with oDepth=0.
REQ-034 SHALL cover: iStall=1 for 5 cycles at oIP=12 with iOp=1 iTarget=50 -> oIP stays 12, then 50 on first cycle with iStall=0.
REQ-035 SHALL cover: 5 nested CALLs with STACK_DEPTH=4 -> guard build: oOverflow=1, oHalted=1, oIP frozen at 5th CALL site; non-guard build: oOverflow=1, oDepth=4, four RETs return to the latest four return addresses.
REQ-036 SHALL cover: RET at oDepth=0 at oIP=7 -> guard: oUnderflow=1, oHalted=1, oIP=7; non-guard: oIP=0, oUnderflow=1; then Reset=0 mid-run clears all flags and oIP=0 asynchronously.
